// File: rtl/bcd_seq_decoder.sv
// Sequential BCD-to-binary converter: MSD-first acc = acc*10 + digit, one digit per clock, valid/ready on both sides.
// Define SEG_INPUT_EN to take raw 7-segment patterns (seg_in) instead of packed BCD (bcd_in).
module bcd_seq_decoder #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef SEG_INPUT_EN
  input  logic [7*DIGITS-1:0]   seg_in,
`else
  input  logic [4*DIGITS-1:0]   bcd_in,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  ovf
);

  localparam int ACC_W = BIN_W + 4;
  localparam int WIDE_W = ACC_W + 4;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  err_acc_q, err_acc_d;
  logic                  ovf_acc_q, ovf_acc_d;

  logic [4*DIGITS-1:0]   cap_dig;
  logic                  cap_err;
  logic [3:0]            cur_dig;
  logic [WIDE_W-1:0]     wide;
  logic [ACC_W-1:0]      acc_next;
  logic                  err_next;
  logic                  ovf_next;

  // acc*10 + d, wide enough that it never wraps for any acc and raw digit 0..15
  function automatic logic [WIDE_W-1:0] mul10_add(input logic [ACC_W-1:0] a, input logic [3:0] d);
    logic [WIDE_W-1:0] ax;
    ax = {4'b0000, a};
    return (ax << 3) + (ax << 1) + {{ACC_W{1'b0}}, d};
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [WIDE_W-1:0] w);
    return (|w[WIDE_W-1:ACC_W]) ? {ACC_W{1'b1}} : w[ACC_W-1:0];
  endfunction

`ifdef SEG_INPUT_EN
  // Returns {illegal, digit}; illegal patterns decode to digit 0
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'b1111110: return 5'h00;
      7'b0110000: return 5'h01;
      7'b1101101: return 5'h02;
      7'b1111001: return 5'h03;
      7'b0110011: return 5'h04;
      7'b1011011: return 5'h05;
      7'b1011111: return 5'h06;
      7'b1110000: return 5'h07;
      7'b1111111: return 5'h08;
      7'b1111011: return 5'h09;
      default:    return 5'h10;
    endcase
  endfunction

  logic [4:0] dec;

  always_comb begin
    cap_dig = '0;
    cap_err = 1'b0;
    dec     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dec                = seg_dec(seg_in[7*i +: 7]);
      cap_dig[4*i +: 4]  = dec[3:0];
      cap_err            = cap_err | dec[4];
    end
  end
`else
  always_comb begin
    cap_dig = bcd_in;
    cap_err = 1'b0;
  end
`endif

  always_comb begin
    cur_dig  = dig_q[4*DIGITS-1 -: 4];
    wide     = mul10_add(acc_q, cur_dig);
    acc_next = sat_acc(wide);
    err_next = err_acc_q | (cur_dig > 4'd9);
    ovf_next = ovf_acc_q | (|wide[WIDE_W-1:BIN_W]);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    bin_d       = bin_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_acc_d   = err_acc_q;
    ovf_acc_d   = ovf_acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          dig_d     = cap_dig;
          acc_d     = '0;
          cnt_d     = CNT_W'(DIGITS - 1);
          err_acc_d = cap_err;
          ovf_acc_d = 1'b0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        acc_d     = acc_next;
        err_acc_d = err_next;
        ovf_acc_d = ovf_next;
        dig_d     = dig_q << 4;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          bin_d       = ovf_next ? {BIN_W{1'b1}} : acc_next[BIN_W-1:0];
          err_d       = err_next;
          ovf_d       = ovf_next;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready tracks the state we are about to enter
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      dig_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_acc_q   <= 1'b0;
      ovf_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_acc_q   <= err_acc_d;
      ovf_acc_q   <= ovf_acc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_seq_decoder.sv
// Bench for bcd_seq_decoder: BIN_W=10 and BIN_W=8 instances share stimulus; results checked against
// a digit-arithmetic reference model.
module tb_bcd_seq_decoder;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic rdy10, rdy8, ov10, ov8, err10, err8, ovf10, ovf8;
  logic [9:0] bin10;
  logic [7:0] bin8;
`ifdef SEG_INPUT_EN
  logic [7*DIGITS-1:0] seg_in;
`else
  logic [4*DIGITS-1:0] bcd_in;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seq_decoder #(.DIGITS(DIGITS), .BIN_W(10)) u10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy10),
`ifdef SEG_INPUT_EN
    .seg_in(seg_in),
`else
    .bcd_in(bcd_in),
`endif
    .out_valid(ov10), .out_ready(out_ready), .bin_out(bin10), .err(err10), .ovf(ovf10));

  bcd_seq_decoder #(.DIGITS(DIGITS), .BIN_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
`ifdef SEG_INPUT_EN
    .seg_in(seg_in),
`else
    .bcd_in(bcd_in),
`endif
    .out_valid(ov8), .out_ready(out_ready), .bin_out(bin8), .err(err8), .ovf(ovf8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  // Nibbles above 9 stand for an illegal segment pattern in segment mode
  task automatic drive_word(input logic [4*DIGITS-1:0] w);
`ifdef SEG_INPUT_EN
    for (int i = 0; i < DIGITS; i++) seg_in[7*i +: 7] = seg_of(w[4*i +: 4]);
`else
    bcd_in = w;
`endif
  endtask

  task automatic model(input logic [4*DIGITS-1:0] w, input int binw,
                       output int bin, output logic e, output logic o);
    int v;
    int d;
    int mx;
    v = 0;
    e = 1'b0;
    mx = (1 << binw) - 1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(w[4*i +: 4]);
      if (d > 9) begin
        e = 1'b1;
`ifdef SEG_INPUT_EN
        d = 0;
`endif
      end
      v = v * 10 + d;
    end
    o = (v > mx);
    bin = o ? mx : v;
  endtask

  task automatic do_word(input logic [4*DIGITS-1:0] w, input int hold);
    int n;
    int e10b, e8b;
    logic e10e, e10o, e8e, e8o;
    model(w, 10, e10b, e10e, e10o);
    model(w, 8, e8b, e8e, e8o);
    n = 0;
    while (rdy10 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_word", {rdy10, rdy8}, 2'b11);
    drive_word(w);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    drive_word((4*DIGITS)'($urandom));
    chk("in_ready_after_accept", rdy10, 1'b0);
    n = 0;
    while (ov10 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, DIGITS);
    chk("out_valid8", ov8, 1'b1);
    chk("bin_out10", bin10, e10b);
    chk("err10", err10, e10e);
    chk("ovf10", ovf10, e10o);
    chk("bin_out8", bin8, e8b);
    chk("err8", err8, e8e);
    chk("ovf8", ovf8, e8o);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      drive_word((4*DIGITS)'($urandom));
      @(negedge clk);
      chk("hold_out_valid", ov10, 1'b1);
      chk("hold_bin_out", bin10, e10b);
      chk("hold_in_ready", rdy10, 1'b0);
    end
    if (hold > 0) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", ov10, 1'b0);
    chk("in_ready_after_hs", rdy10, 1'b1);
    chk("bin_out_kept", bin10, e10b);
    chk("err_kept", err10, e10e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_word('0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", rdy10, 1'b0);
    chk("reset_out_valid", ov10, 1'b0);
    chk("reset_outputs", {bin10, err10, ovf10}, 12'h000);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", rdy10, 1'b0);
    @(negedge clk);
    chk("in_ready_first_edge", rdy10, 1'b1);

    do_word(12'h255, 0);
    do_word(12'h999, 0);
    do_word(12'h1A3, 0);
    do_word(12'h2A5, 1);
    do_word(12'h555, 5);
    do_word(12'h007, 0);

    // Abort a conversion with reset while outputs carry a prior nonzero result
    drive_word(12'h888);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {ov10, rdy10, bin10, err10, ovf10}, 14'h0);
    chk("abort_outputs8", {ov8, rdy8, bin8, err8, ovf8}, 12'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_valid", ov10, 1'b0);
    rst_n = 1'b1;
    do_word(12'h042, 0);

    for (int t = 0; t < 30; t++) begin
      logic [4*DIGITS-1:0] w;
      for (int i = 0; i < DIGITS; i++)
        w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      do_word(w, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
